uart_tx_parity: RTL and testbench

- Transmit half of the UART: serialises one parallel data word into a standard asynchronous frame on `TXD`.
- Frame is start bit, `DWIDTH` data bits LSB first, optional parity bit, then stop bit.
- The parity bit follows the same `PARITYSEL` convention as the receive-side parity checker, so a looped-back frame re-assembled as `{parity, data}` checks clean.
- Sits between the host write interface (valid/ready) and the serial line.

---
 rtl/uart_tx_parity.sv | 123 ++++++++++++
 tb/tb_uart_tx_parity.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DWIDTH data bits LSB first, optional parity bit, stop bit.
// TXD and BUSY are registered from the next-state decode, so both change exactly on state changes.
//
// state  | meaning
// IDLE   | line high, tx_ready asserted, waiting for tx_valid
// START  | driving the start bit (0)
// DATA   | driving shift register LSB, one bit per baud period
// PARITY | driving the parity bit latched at acceptance
// STOP   | driving the stop bit (1)
module uart_tx_parity #(
   parameter int DWIDTH       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DWIDTH-1:0] data_in,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              PARITYEN,
   input  logic              PARITYSEL,
   output logic              TXD,
   output logic              BUSY
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            state_q, state_nx;
   logic [CW-1:0]     baud_q, baud_nx;
   logic [BW-1:0]     bit_q, bit_nx;
   logic [DWIDTH-1:0] shreg_q, shreg_nx;
   logic              par_en_q, par_en_nx;
   logic              par_bit_q, par_bit_nx;
   logic              txd_nx, busy_nx;
   logic              accept, baud_tc, last_bit;

   assign tx_ready = (state_q == S_IDLE);
   assign accept   = tx_valid & tx_ready;
   assign baud_tc  = (baud_q == CW'(CLKS_PER_BIT - 1));
   assign last_bit = (bit_q == BW'(DWIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_nx = S_START;
         S_START:  if (baud_tc) state_nx = S_DATA;
         S_DATA:   if (baud_tc && last_bit) state_nx = par_en_q ? S_PARITY : S_STOP;
         S_PARITY: if (baud_tc) state_nx = S_STOP;
         S_STOP:   if (baud_tc) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath: counters only advance outside IDLE and clear on terminal count.
   always_comb begin
      baud_nx    = baud_q;
      bit_nx     = bit_q;
      shreg_nx   = shreg_q;
      par_en_nx  = par_en_q;
      par_bit_nx = par_bit_q;
      if (state_q == S_IDLE) begin
         baud_nx = '0;
         bit_nx  = '0;
         if (accept) begin
            shreg_nx   = data_in;
            par_en_nx  = PARITYEN;
            par_bit_nx = PARITYSEL ? ~^data_in : ^data_in;
         end
      end else if (baud_tc) begin
         baud_nx = '0;
         if (state_q == S_DATA) begin
            shreg_nx = shreg_q >> 1;
            if (!last_bit) bit_nx = bit_q + 1'b1;
         end
      end else begin
         baud_nx = baud_q + 1'b1;
      end
   end

   always_comb begin
      busy_nx = (state_nx != S_IDLE);
      case (state_nx)
         S_START:  txd_nx = 1'b0;
         S_DATA:   txd_nx = shreg_nx[0];
         S_PARITY: txd_nx = par_bit_nx;
         default:  txd_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q    <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         TXD       <= 1'b1;
         BUSY      <= 1'b0;
      end else begin
         baud_q    <= baud_nx;
         bit_q     <= bit_nx;
         shreg_q   <= shreg_nx;
         par_en_q  <= par_en_nx;
         par_bit_q <= par_bit_nx;
         TXD       <= txd_nx;
         BUSY      <= busy_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Self-checking bench for uart_tx_parity: directed vector table, hand-written corner
// sequences and random frames compared against a slot-level frame model.
module tb_uart_tx_parity;

   localparam int C = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx_valid = 1'b0;
   logic       PARITYEN = 1'b0;
   logic       PARITYSEL = 1'b0;
   logic       tx_ready, TXD, BUSY;

   int n_vec = 0;
   int n_err = 0;

   logic cap_txd [0:511];
   logic cap_busy[0:511];
   logic cap_rdy [0:511];

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       ps;
      logic       exp_par;
      int         exp_len;
   } vec_t;

   vec_t tbl[6];

   uart_tx_parity #(.DWIDTH(8), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .PARITYEN(PARITYEN), .PARITYSEL(PARITYSEL),
      .TXD(TXD), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Line value expected in bit slot s of a frame (slot 0 = start bit).
   function automatic logic exp_slot(input logic [7:0] d, input logic pe, input logic ps, input int s);
      if (s == 0) return 1'b0;
      if (s <= 8) return d[s-1];
      if (pe && s == 9) return logic'(($countones(d) % 2 == 1) ^ ps);
      return 1'b1;
   endfunction

   // Receive-side checker: error when the total ones count disagrees with the chosen parity.
   function automatic int parity_err(input logic [7:0] d, input logic p, input logic ps);
      int total;
      total = $countones(d) + int'(p);
      return (total % 2) ^ int'(ps);
   endfunction

   task automatic store(input int c);
      cap_txd[c]  = TXD;
      cap_busy[c] = BUSY;
      cap_rdy[c]  = tx_ready;
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic accept_word(input logic [7:0] d, input logic pe, input logic ps,
                              input logic keep_valid, output logic ok);
      logic r;
      data_in   = d;
      PARITYEN  = pe;
      PARITYSEL = ps;
      tx_valid  = 1'b1;
      ok = 1'b0;
      for (int g = 0; g < 400; g++) begin
         r = tx_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      if (!keep_valid) tx_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic check_frame(input string name, input logic [7:0] d, input logic pe,
                              input logic ps, input int base, output logic p_r, output int nb);
      int f, bad;
      logic [7:0] d_r;
      f = (10 + int'(pe)) * C;
      bad = 0;
      nb = 0;
      for (int c = 0; c < f; c++) begin
         if (cap_txd[base+c] !== exp_slot(d, pe, ps, c / C) || cap_rdy[base+c] !== 1'b0) bad++;
      end
      for (int c = 0; c <= f; c++) nb += int'(cap_busy[base+c]);
      chk({name, "_line"}, bad, 0);
      chk({name, "_end_idle"}, int'({cap_txd[base+f], cap_rdy[base+f], cap_busy[base+f]}), 3'b110);
      for (int i = 0; i < 8; i++) d_r[i] = cap_txd[base + (1+i)*C + C/2];
      p_r = cap_txd[base + 9*C + C/2];
      if (pe) begin
         chk({name, "_loop_ok"}, parity_err(d_r, p_r, ps), 0);
         chk({name, "_loop_inv"}, parity_err(d_r, ~p_r, ps), 1);
      end
   endtask

   task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                            input logic ps, output logic p_r, output int nb);
      logic ok;
      accept_word(d, pe, ps, 1'b0, ok);
      p_r = 1'b0;
      nb = 0;
      if (!ok) return;
      // Inputs wander during the frame; the latched copies must win.
      data_in   = 8'($urandom);
      PARITYEN  = ~pe;
      PARITYSEL = ~ps;
      store(0);
      for (int c = 1; c <= (10 + int'(pe)) * C + 1; c++) begin
         @(posedge clk);
         #1;
         store(c);
      end
      check_frame(name, d, pe, ps, 0, p_r, nb);
   endtask

   initial begin
      logic p_r, ok;
      int nb, bad, f;
      logic [7:0] rd;
      logic rpe, rps;

      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 176};
      tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 176};
      tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 176};
      tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 160};
      tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 176};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 176};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_txd", int'(TXD), 1);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_ready", int'(tx_ready), 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].pe, tbl[i].ps, p_r, nb);
         chk($sformatf("tbl%0d_busy_len", i), nb, tbl[i].exp_len);
         if (tbl[i].pe) chk($sformatf("tbl%0d_parity", i), int'(p_r), int'(tbl[i].exp_par));
      end

      // Reset during a data bit that is driving 0.
      accept_word(8'hA5, 1'b1, 1'b0, 1'b0, ok);
      repeat (40) @(posedge clk);
      #3;
      chk("pre_rst_txd", int'(TXD), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_txd", int'(TXD), 1);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_ready", int'(tx_ready), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (TXD !== 1'b1 || BUSY !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      chk("idle_200", bad, 0);

      // Back-to-back with tx_valid held, then a dropped pulse mid-frame.
      f = 11 * C;
      accept_word(8'h00, 1'b1, 1'b0, 1'b1, ok);
      data_in = 8'hFF;
      store(0);
      for (int c = 1; c <= 2*f + 7; c++) begin
         @(posedge clk);
         #1;
         store(c);
         if (c == f + 1) tx_valid = 1'b0;
         if (c == f + 60) begin
            data_in  = 8'h3C;
            tx_valid = 1'b1;
         end
         if (c == f + 61) tx_valid = 1'b0;
      end
      check_frame("b2b_first", 8'h00, 1'b1, 1'b0, 0, p_r, nb);
      chk("b2b_first_busy", nb, f);
      chk("b2b_gap", int'({cap_txd[f], cap_rdy[f]}), 3);
      chk("b2b_second_start", int'(cap_txd[f+1]), 0);
      check_frame("b2b_second", 8'hFF, 1'b1, 1'b0, f + 1, p_r, nb);
      chk("b2b_second_busy", nb, f);
      bad = 0;
      for (int c = 2*f + 1; c <= 2*f + 7; c++)
         if (cap_txd[c] !== 1'b1 || cap_busy[c] !== 1'b0) bad++;
      chk("pulse_dropped", bad, 0);

      for (int i = 0; i < 40; i++) begin
         rd  = 8'($urandom_range(0, 255));
         rpe = 1'($urandom_range(0, 1));
         rps = 1'($urandom_range(0, 1));
         run_frame($sformatf("rnd%0d", i), rd, rpe, rps, p_r, nb);
         chk($sformatf("rnd%0d_busy_len", i), nb, (10 + int'(rpe)) * C);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
